// File: rtl/etm_mul_pipe.sv
// etm_mul_pipe: pipelined error-tolerant multiplier.
// The high operand segments are always multiplied exactly. The low segment is
// either Mitchell-approximated, truncated to zero, or multiplied exactly.
// Three register stages are linked by a valid/ready chain that lets bubbles
// collapse. A saturating counter records how many approximate results were
// delivered.
module etm_mul_pipe #(
  parameter int WIDTH = 16,
  parameter int SPLIT = WIDTH / 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   c,
  output logic                 c_approx,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     approx_cnt
);

  localparam int L  = SPLIT;
  localparam int H  = WIDTH - SPLIT;
  localparam int KW = $clog2(L);
  localparam logic [L-1:0]   ONE_L  = {{(L-1){1'b0}}, 1'b1};
  localparam logic [2*L-1:0] ONE_2L = {{(2*L-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    PATH_EXACT,
    PATH_LOW,
    PATH_MITCH,
    PATH_TRUNC
  } path_t;

  // Position of the most significant set bit; zero for a zero input.
  function automatic logic [KW-1:0] lead_one(input logic [L-1:0] x);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < L; i++) begin
      if (x[i]) k = KW'(i);
    end
    return k;
  endfunction

  logic v1, v2, v3;
  logic rdy1, rdy2, rdy3;

  assign rdy3     = !v3 || out_ready;
  assign rdy2     = !v2 || rdy3;
  assign rdy1     = !v1 || rdy2;
  assign in_ready = rdy1;

  // Stage 1 inputs: path selection and leading-one analysis of the low halves.
  logic [H-1:0]  a_hi_in, b_hi_in;
  logic [L-1:0]  a_lo_in, b_lo_in, fx_in, fy_in;
  logic [KW-1:0] kx_in, ky_in;
  logic          zero_in;
  path_t         path_in;

  assign a_hi_in = a[WIDTH-1:L];
  assign b_hi_in = b[WIDTH-1:L];
  assign a_lo_in = a[L-1:0];
  assign b_lo_in = b[L-1:0];

  // Choose the arithmetic path for the incoming beat and strip the leading ones.
  always_comb begin
    path_in = PATH_EXACT;
    if (mode[1])
      path_in = PATH_EXACT;
    else if (a_hi_in == '0 && b_hi_in == '0)
      path_in = PATH_LOW;
    else if (mode[0])
      path_in = PATH_TRUNC;
    else
      path_in = PATH_MITCH;
    kx_in   = lead_one(a_lo_in);
    ky_in   = lead_one(b_lo_in);
    fx_in   = a_lo_in & ~(ONE_L << kx_in);
    fy_in   = b_lo_in & ~(ONE_L << ky_in);
    zero_in = (a_lo_in == '0) || (b_lo_in == '0);
  end

  logic [WIDTH-1:0] s1_a, s1_b;
  logic [L-1:0]     s1_fx, s1_fy;
  logic [KW-1:0]    s1_kx, s1_ky;
  logic             s1_zero;
  path_t            s1_path;

  // Stage 1 register: accept a new beat whenever this stage can move.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (rdy1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_fx   <= fx_in;
        s1_fy   <= fy_in;
        s1_kx   <= kx_in;
        s1_ky   <= ky_in;
        s1_zero <= zero_in;
        s1_path <= path_in;
      end
    end
  end

  // Stage 2 inputs: one shared multiplier whose operands depend on the path.
  logic [WIDTH-1:0]   op_a, op_b;
  logic [2*WIDTH-1:0] prod_in;
  logic [2*L-1:0]     s_in, t_in;

  // Pick multiplier operands and form the Mitchell sum and reference power.
  always_comb begin
    op_a = s1_a;
    op_b = s1_b;
    case (s1_path)
      PATH_LOW: begin
        op_a = {{H{1'b0}}, s1_a[L-1:0]};
        op_b = {{H{1'b0}}, s1_b[L-1:0]};
      end
      PATH_MITCH, PATH_TRUNC: begin
        op_a = {{L{1'b0}}, s1_a[WIDTH-1:L]};
        op_b = {{L{1'b0}}, s1_b[WIDTH-1:L]};
      end
      default: begin
        op_a = s1_a;
        op_b = s1_b;
      end
    endcase
    prod_in = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
    s_in = ({{L{1'b0}}, s1_fx} << s1_ky) + ({{L{1'b0}}, s1_fy} << s1_kx);
    t_in = ONE_2L << ({1'b0, s1_kx} + {1'b0, s1_ky});
    if (s1_zero) begin
      s_in = '0;
      t_in = '0;
    end
  end

  logic [2*WIDTH-1:0] s2_prod;
  logic [2*L-1:0]     s2_s, s2_t;
  path_t              s2_path;

  // Stage 2 register: advance from stage 1 when downstream has room.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
    end else if (rdy2) begin
      v2 <= v1;
      if (v1) begin
        s2_prod <= prod_in;
        s2_s    <= s_in;
        s2_t    <= t_in;
        s2_path <= s1_path;
      end
    end
  end

  // Stage 3 inputs: finish Mitchell and place the high product above the low part.
  logic [2*L-1:0]     mitch_low;
  logic [2*WIDTH-1:0] c_in;
  logic               approx_in;

  // Build the final product and flag approximate results.
  always_comb begin
    mitch_low = (s2_s < s2_t) ? (s2_t + s2_s) : (s2_s << 1);
    c_in      = s2_prod;
    approx_in = 1'b0;
    case (s2_path)
      PATH_MITCH: begin
        c_in      = (s2_prod << (2 * L)) | {{(2*H){1'b0}}, mitch_low};
        approx_in = 1'b1;
      end
      PATH_TRUNC: begin
        c_in      = s2_prod << (2 * L);
        approx_in = 1'b1;
      end
      default: begin
        c_in      = s2_prod;
        approx_in = 1'b0;
      end
    endcase
  end

  logic [2*WIDTH-1:0] c_r;
  logic               approx_r;

  // Output register: holds its result steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3       <= 1'b0;
      c_r      <= '0;
      approx_r <= 1'b0;
    end else if (rdy3) begin
      v3 <= v2;
      if (v2) begin
        c_r      <= c_in;
        approx_r <= approx_in;
      end
    end
  end

  logic [CNT_W-1:0] cnt_r;

  // Count delivered approximate results, saturating; a clear takes priority.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_r <= '0;
    else if (cnt_clr)
      cnt_r <= '0;
    else if (v3 && out_ready && approx_r && (cnt_r != '1))
      cnt_r <= cnt_r + 1'b1;
  end

  assign out_valid  = v3;
  assign c          = c_r;
  assign c_approx   = approx_r;
  assign approx_cnt = cnt_r;

endmodule

// File: tb/tb_etm_mul_pipe.sv
// tb_etm_mul_pipe: directed and randomized checks of etm_mul_pipe against an
// arithmetic reference model, with a scoreboard queue of accepted beats.
module tb_etm_mul_pipe;

  localparam int WIDTH = 16;
  localparam int SPLIT = 8;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
  logic        c_approx;
  logic        cnt_clr;
  logic [3:0]  approx_cnt;

  etm_mul_pipe #(.WIDTH(WIDTH), .SPLIT(SPLIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .c_approx(c_approx), .cnt_clr(cnt_clr), .approx_cnt(approx_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] c;
    logic        approx;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          cnt_model = 0;
  bit          mon_en = 0;
  bit          check_lat = 0;
  bit          rand_done = 0;
  bit          stall_prev = 0;
  logic [31:0] stall_c;
  logic        stall_approx;
  logic [31:0] last_c;
  logic        last_approx;

  function automatic longint unsigned mitchell(input longint unsigned x, input longint unsigned y);
    longint unsigned kx, ky, fx, fy, s, t;
    if (x == 0 || y == 0) return 0;
    kx = 0;
    while ((x >> (kx + 1)) != 0) kx++;
    ky = 0;
    while ((y >> (ky + 1)) != 0) ky++;
    fx = x - (64'd1 << kx);
    fy = y - (64'd1 << ky);
    s  = (fx << ky) + (fy << kx);
    t  = 64'd1 << (kx + ky);
    return (s < t) ? (t + s) : (2 * s);
  endfunction

  // Returns {approx, product}.
  function automatic logic [32:0] model(input logic [15:0] av, input logic [15:0] bv, input logic [1:0] m);
    longint unsigned ah, al, bh, bl, p, low;
    ah = longint'(av) / 256;
    al = longint'(av) % 256;
    bh = longint'(bv) / 256;
    bl = longint'(bv) % 256;
    if (m >= 2) begin
      p = longint'(av) * longint'(bv);
      return {1'b0, p[31:0]};
    end
    if (ah == 0 && bh == 0) begin
      p = al * bl;
      return {1'b0, p[31:0]};
    end
    low = (m == 1) ? 0 : mitchell(al, bl);
    p = ah * bh * 65536 + low;
    return {1'b1, p[31:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: record accepts, compare retires, track counter and stall stability.
  always @(negedge clk) begin
    exp_t        e;
    logic [32:0] r;
    cyc++;
    if (mon_en) begin
      if (rst) begin
        q.delete();
        cnt_model  = 0;
        stall_prev = 0;
      end else begin
        checkOutput("approx_cnt", 64'(approx_cnt), 64'(cnt_model));
        checkOutput("in_ready", 64'(in_ready), 64'(!(q.size() == 3 && !out_ready)));
        if (stall_prev) begin
          checkOutput("stall_valid", 64'(out_valid), 64'd1);
          checkOutput("stall_c", 64'(c), 64'(stall_c));
          checkOutput("stall_approx", 64'(c_approx), 64'(stall_approx));
        end
        if (out_valid && q.size() == 0) begin
          checkOutput("out_valid_empty", 64'(out_valid), 64'd0);
        end else if (out_valid && out_ready) begin
          e = q.pop_front();
          checkOutput("c", 64'(c), 64'(e.c));
          checkOutput("c_approx", 64'(c_approx), 64'(e.approx));
          if (check_lat) checkOutput("latency", 64'(cyc - e.cyc), 64'd3);
          last_c      = c;
          last_approx = c_approx;
          if (e.approx && cnt_model < 15) cnt_model++;
        end
        if (cnt_clr) cnt_model = 0;
        stall_prev   = out_valid && !out_ready;
        stall_c      = c;
        stall_approx = c_approx;
        if (in_valid && in_ready) begin
          r = model(a, b, mode);
          e.c = r[31:0];
          e.approx = r[32];
          e.cyc = cyc;
          q.push_back(e);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic [1:0] m);
    bit got;
    a = av;
    b = bv;
    mode = m;
    in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    checkOutput("drain", 64'(q.size()), 64'd0);
    #1;
  endtask

  task automatic directed(input logic [15:0] av, input logic [15:0] bv, input logic [1:0] m,
                          input logic [31:0] exp_c, input logic exp_a, input string name);
    applyStimulus(av, bv, m);
    waitDrain();
    checkOutput({name, "_c"}, 64'(last_c), 64'(exp_c));
    checkOutput({name, "_approx"}, 64'(last_approx), 64'(exp_a));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    a = '0;
    b = '0;
    mode = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1;
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_c", 64'(c), 64'd0);
    checkOutput("rst_c_approx", 64'(c_approx), 64'd0);
    checkOutput("rst_cnt", 64'(approx_cnt), 64'd0);
    @(posedge clk);
    #1;

    checkOutput("model_low", 64'(model(16'd200, 16'd100, 2'b00)), 64'h0_00004E20);
    checkOutput("model_mitch_ge", 64'(model(16'h1234, 16'h0567, 2'b00)), 64'h1_005A13C0);
    checkOutput("model_exact", 64'(model(16'h1234, 16'h0567, 2'b10)), 64'h0_006256EC);
    checkOutput("model_mitch_lt", 64'(model(16'h0103, 16'h0105, 2'b00)), 64'h1_0001000E);
    checkOutput("model_trunc", 64'(model(16'h0103, 16'h0105, 2'b01)), 64'h1_00010000);
    checkOutput("model_zero_lo", 64'(model(16'h0100, 16'h0100, 2'b00)), 64'h1_00010000);

    $display("[TB] directed paths");
    check_lat = 1;
    directed(16'd200, 16'd100, 2'b00, 32'd20000, 1'b0, "exact_low");
    directed(16'h1234, 16'h0567, 2'b00, 32'h005A13C0, 1'b1, "mitch_ge");
    directed(16'h1234, 16'h0567, 2'b10, 32'h006256EC, 1'b0, "exact");
    directed(16'h0103, 16'h0105, 2'b00, 32'h0001000E, 1'b1, "mitch_lt");
    directed(16'h0103, 16'h0105, 2'b01, 32'h00010000, 1'b1, "trunc");
    directed(16'h0100, 16'h0100, 2'b00, 32'h00010000, 1'b1, "zero_lo");
    directed(16'h00FF, 16'h0000, 2'b11, 32'h00000000, 1'b0, "zero_b");
    for (int i = 0; i < 6; i++) applyStimulus(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
    waitDrain();
    check_lat = 0;

    $display("[TB] fill pipe under stall");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(16'($urandom), 16'($urandom), 2'b00);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    waitDrain();

    $display("[TB] randomized backpressure");
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [15:0] ra, rb;
          ra = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
          rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
          applyStimulus(ra, rb, 2'($urandom_range(0, 3)));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    waitDrain();

    $display("[TB] reset mid-operation");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(16'h0F00 | 16'($urandom_range(0, 255)), 16'h0300, 2'b00);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("post_rst_cnt", 64'(approx_cnt), 64'd0);
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("post_rst_idle", 64'(out_valid), 64'd0);

    $display("[TB] counter saturation and clear");
    for (int i = 0; i < 20; i++) applyStimulus(16'h0F00 | 16'($urandom_range(0, 255)), 16'h0300, 2'b01);
    waitDrain();
    checkOutput("cnt_sat", 64'(approx_cnt), 64'd15);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    checkOutput("cnt_clr", 64'(approx_cnt), 64'd0);
    for (int i = 0; i < 2; i++) applyStimulus(16'h0500, 16'h0A00, 2'b00);
    waitDrain();
    checkOutput("cnt_two", 64'(approx_cnt), 64'd2);
    out_ready = 1'b0;
    applyStimulus(16'h0700, 16'h0123, 2'b01);
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      @(posedge clk);
      #1;
    end
    checkOutput("clr_beat_valid", 64'(out_valid), 64'd1);
    cnt_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    checkOutput("cnt_clr_wins", 64'(approx_cnt), 64'd0);
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
